// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte sources. A source that wins
// round-robin arbitration keeps the grant until its last byte has been sent.
// Each byte is handed over with one tx_start. The arbiter then waits for
// tx_done before it takes the next byte. A watchdog drops the grant when the
// transmitter stalls in WAIT or the owner stalls in HOLD.

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65536,
    parameter int TO_W        = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*8-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [TO_W-1:0]  CNT_EXPIRED = TO_W'(TIMEOUT_CYC - 1);

    // Registered state and its next-state values
    logic [1:0]       state_q,       state_d;
    logic [IDX_W-1:0] rr_ptr_q,      rr_ptr_d;
    logic [IDX_W-1:0] owner_q,       owner_d;
    logic             last_q,        last_d;
    logic [TO_W-1:0]  cnt_q,         cnt_d;
    logic [7:0]       tx_data_q,     tx_data_d;
    logic             timeout_err_q, timeout_err_d;

    // Arbitration helpers
    logic [7:0]         req_byte_s [NUM_REQ];
    logic [NUM_REQ-1:0] rot_s;
    logic [IDX_W-1:0]   off_s;
    logic [IDX_W:0]     sum_s;
    logic [IDX_W-1:0]   win_s;
    logic               any_valid_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic               cnt_expired_s;

    // Slice the flat data bus into one byte per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
        assign req_byte_s[g] = req_data[8*g+7 : 8*g];
    end

    // Round-robin search: rotate req_valid so rr_ptr lands at bit 0, take the lowest set bit, rotate back
    always_comb begin
        rot_s = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        off_s = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? IDX_W'(j) : off_s;
        end
        sum_s       = {1'b0, rr_ptr_q} + {1'b0, off_s};
        win_s       = (sum_s >= NUM_REQ_W) ? IDX_W'(sum_s - NUM_REQ_W) : IDX_W'(sum_s);
        any_valid_s = |req_valid;
    end

    // Pointer after the current owner releases (wraps to 0 after the last index), and the watchdog limit
    always_comb begin
        next_ptr_s    = (owner_q == LAST_IDX) ? {IDX_W{1'b0}} : owner_q + {{(IDX_W-1){1'b0}}, 1'b1};
        cnt_expired_s = (cnt_q == CNT_EXPIRED);
    end

    // Next-state logic of the sequencing FSM, including the watchdog release
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    owner_d   = win_s;
                    tx_data_d = req_byte_s[win_s];
                    last_d    = req_last[win_s];
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                cnt_d   = {TO_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // tx_done wins over a watchdog expiry in the same cycle
                if (tx_done) begin
                    cnt_d = {TO_W{1'b0}};
                    if (last_q) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d  = ST_HOLD;
                    end
                end else if (cnt_expired_s) begin
                    state_d       = ST_IDLE;
                    rr_ptr_d      = next_ptr_s;
                    cnt_d         = {TO_W{1'b0}};
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                // Only the owner is looked at; a stray tx_done here is ignored
                if (req_valid[owner_q]) begin
                    tx_data_d = req_byte_s[owner_q];
                    last_d    = req_last[owner_q];
                    state_d   = ST_SEND;
                end else if (cnt_expired_s) begin
                    state_d       = ST_IDLE;
                    rr_ptr_d      = next_ptr_s;
                    cnt_d         = {TO_W{1'b0}};
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any message in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= {IDX_W{1'b0}};
            owner_q       <= {IDX_W{1'b0}};
            last_q        <= 1'b0;
            cnt_q         <= {TO_W{1'b0}};
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Handshake outputs are decoded from the state register only
    assign req_ready   = (state_q == ST_SEND) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q)
                                              : {NUM_REQ{1'b0}};
    assign tx_start    = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = owner_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYC=100).
// The requesters are byte queues. The transmitter is a tx_done delay model.
// Expected grants come from a message-level round-robin model over the queued messages.

module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (100),
        .TO_W        (24)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Requester byte queues: bit 8 = last flag
    logic [8:0] qm [4][64];
    int qh [4];
    int qt [4];

    // Expected sequence of (owner, byte) per tx_start
    int         exp_id   [512];
    logic [7:0] exp_byte [512];
    int exp_rd = 0;
    int exp_wr = 0;
    int m_ptr  = 0;

    // Transmitter model
    bit tx_pending  = 1'b0;
    int tx_cnt      = 0;
    bit auto_done   = 1'b1;
    int dly_lo      = 1;
    int dly_hi      = 1;
    bit inject_done = 1'b0;
    bit allow_to    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b, input logic last);
        if (qh[id] == qt[id]) begin
            qh[id] = 0;
            qt[id] = 0;
        end
        qm[id][qt[id]] = {last, b};
        qt[id]++;
    endtask

    task automatic expect_push(input int id, input logic [7:0] b);
        exp_id[exp_wr]   = id;
        exp_byte[exp_wr] = b;
        exp_wr++;
    endtask

    // Message-level round robin over everything currently queued
    task automatic build_expect();
        int  h [4];
        int  found;
        int  idx;
        bit  more;
        bit  fin;
        for (int i = 0; i < 4; i++) h[i] = qh[i];
        more = 1'b1;
        while (more) begin
            found = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (found < 0 && h[idx] < qt[idx]) found = idx;
            end
            if (found < 0) begin
                more = 1'b0;
            end else begin
                fin = 1'b0;
                while (!fin && h[found] < qt[found]) begin
                    expect_push(found, qm[found][h[found]][7:0]);
                    fin = qm[found][h[found]][8];
                    h[found]++;
                end
                m_ptr = (found + 1) % 4;
            end
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (qh[i] < qt[i]) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = qm[i][qh[i]][7:0];
                req_last[i]       = qm[i][qh[i]][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // One cycle: sample at negedge, check, update requesters and transmitter, drive
    task automatic tick();
        bit started;
        @(negedge clk);
        started = 1'b0;
        if (tx_start === 1'b1) begin
            started = 1'b1;
            if (exp_rd < exp_wr) begin
                check("grant_id", grant_id, exp_id[exp_rd]);
                check("tx_data", tx_data, exp_byte[exp_rd]);
                check("req_ready_send", req_ready, 4'b0001 << exp_id[exp_rd]);
                exp_rd++;
            end else begin
                check("tx_start_unexpected", tx_start, 1'b0);
            end
            tx_pending = auto_done;
            tx_cnt     = $urandom_range(dly_hi, dly_lo);
        end else begin
            check("req_ready_quiet", req_ready, 4'b0000);
        end
        if (!allow_to) check("timeout_err_spurious", timeout_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i] === 1'b1) qh[i]++;
        end
        tx_done = 1'b0;
        if (inject_done) begin
            tx_done     = 1'b1;
            inject_done = 1'b0;
        end else if (tx_pending && !started) begin
            tx_cnt--;
            if (tx_cnt <= 0) begin
                tx_done    = 1'b1;
                tx_pending = 1'b0;
            end
        end
        drive_reqs();
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_rd < exp_wr || busy === 1'b1 || tx_pending) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_rd, exp_wr);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_start(input string tag);
        int rd0;
        int n;
        rd0 = exp_rd;
        n   = 0;
        while (exp_rd == rd0 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_started"}, exp_rd, rd0 + 1);
    endtask

    task automatic wait_done_driven(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (tx_done !== 1'b1 && n < 200);
        check({tag, "_done_seen"}, tx_done, 1'b1);
    endtask

    task automatic count_to_timeout(output int n);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 10 && busy === 1'b1 && tx_pending == 1'b0 && dly_lo == 5) inject_done = 1'b1;
        end while (timeout_err !== 1'b1 && n < 300);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        rst_n     = 1'b0;
        tx_done   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_timeout_err", timeout_err, 1'b0);
        rst_n = 1'b1;

        // T1: single byte from req0, tx_done 19 cycles after tx_start
        dly_lo = 19; dly_hi = 19; auto_done = 1'b1;
        push(0, 8'h55, 1'b1);
        build_expect();
        drive_reqs();
        tick();
        check("t1_tx_start", tx_start, 1'b1);
        check("t1_req_ready", req_ready, 4'b0001);
        check("t1_tx_data", tx_data, 8'h55);
        wait_done_driven("t1");
        check("t1_busy_in_wait", busy, 1'b1);
        tick();
        check("t1_busy_after_done", busy, 1'b0);

        // T2: all four valid; rr_ptr is 1 after T1, so grants go 1,2,3,0 and the pointer wraps
        dly_lo = 10; dly_hi = 10;
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        build_expect();
        check("t2_first_owner_model", exp_id[exp_rd], 1);
        drive_reqs();
        drain(1000, "t2");

        // T3: three-byte message from req1 while req2 waits
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        push(2, 8'h44, 1'b1);
        build_expect();
        drive_reqs();
        drain(1000, "t3");

        // T4: req3 granted, transmitter never answers; req0 follows after the watchdog
        auto_done = 1'b0;
        push(3, 8'h3C, 1'b1);
        push(0, 8'h0C, 1'b1);
        build_expect();
        drive_reqs();
        wait_start("t4");
        allow_to = 1'b1;
        count_to_timeout(n);
        check("t4_timeout_latency", n, 101);
        check("t4_timeout_pulse", timeout_err, 1'b1);
        check("t4_idle_on_timeout", busy, 1'b0);
        allow_to  = 1'b0;
        auto_done = 1'b1;
        tick();
        check("t4_req0_next", tx_start, 1'b1);
        drain(1000, "t4");

        // T5: req2 stalls mid-message; a stray tx_done in HOLD must not matter
        dly_lo = 5; dly_hi = 5;
        push(2, 8'h21, 1'b0);
        expect_push(2, 8'h21);
        drive_reqs();
        wait_start("t5");
        wait_done_driven("t5");
        allow_to = 1'b1;
        count_to_timeout(n);
        check("t5_timeout_latency", n, 101);
        check("t5_idle_on_timeout", busy, 1'b0);
        allow_to = 1'b0;
        m_ptr = 3;
        repeat (90) tick();
        push(2, 8'h22, 1'b1);
        build_expect();
        drive_reqs();
        drain(1000, "t5");

        // T6: reset while waiting for tx_done; pending req2/req3 are re-arbitrated from pointer 0
        auto_done = 1'b0;
        push(1, 8'h61, 1'b1);
        build_expect();
        drive_reqs();
        wait_start("t6");
        repeat (3) tick();
        push(2, 8'h62, 1'b1);
        push(3, 8'h63, 1'b1);
        drive_reqs();
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_tx_start", tx_start, 1'b0);
        check("t6_rst_req_ready", req_ready, 4'b0000);
        check("t6_rst_tx_data", tx_data, 8'h00);
        check("t6_rst_grant_id", grant_id, 2'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        tx_pending = 1'b0;
        tx_done    = 1'b0;
        exp_rd     = exp_wr;
        auto_done  = 1'b1;
        m_ptr      = 0;
        dly_lo = 1; dly_hi = 30;
        build_expect();
        tick();
        check("t6_send_after_reset", tx_start, 1'b1);
        check("t6_owner_after_reset", grant_id, 2'd2);
        drain(1000, "t6");

        // Randomised rounds: random messages per requester, random transmitter latency
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) begin
                int nm;
                nm = $urandom_range(2, 0);
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(3, 1);
                    for (int b = 0; b < len; b++) begin
                        push(i, 8'($urandom_range(255, 0)), (b == len - 1));
                    end
                end
            end
            build_expect();
            drive_reqs();
            drain(4000, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
